mult_operand_feeder: RTL

Upstream feeder for the 32×32 shift-add multiplier, which has an 8-bit operand bus. The block accepts 32-bit operand pairs on a valid/ready handshake and buffers them in a small FIFO. When the multiplier reports `rdy`, the block issues a one-cycle `start`. It then drives the operand bytes on `M` in the interleaved, cycle-exact order the multiplier samples. It sits between the operand source (CPU/test harness side) and the multiplier's `start`/`M`/`rdy` pins.

---
 rtl/mult_feed_pkg.sv | 44 ++++
 rtl/op_fifo.sv | 59 +++++
 rtl/mult_operand_feeder.sv | 103 ++++++++++
 3 files changed

// File: rtl/mult_feed_pkg.sv
// Shared types and constants for the shift-add multiplier operand feeder.
// Holds the FSM encoding and the byte-order helper used on the 8-bit bus.
package mult_feed_pkg;

    localparam int OPND_W     = 32;
    localparam int BUS_W      = 8;
    localparam int FEED_BYTES = 9;

    localparam logic [3:0] LAST_IDX = 4'(FEED_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        GAP      = 3'd2,
        FEED     = 3'd3,
        WAIT_RDY = 3'd4
    } feed_state_t;

    // Pair is packed {A, B}; bytes interleave A/B low-to-high, then A[7:0] again
    // because the multiplier re-samples its low operand byte on the extra cycle.
    function automatic logic [BUS_W-1:0] feed_byte(input logic [2*OPND_W-1:0] pair,
                                                   input logic [3:0]          idx);
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
        logic [BUS_W-1:0]  res;
        a = pair[2*OPND_W-1:OPND_W];
        b = pair[OPND_W-1:0];
        res = '0;
        case (idx)
            4'd0:    res = a[7:0];
            4'd1:    res = b[7:0];
            4'd2:    res = a[15:8];
            4'd3:    res = b[15:8];
            4'd4:    res = a[23:16];
            4'd5:    res = b[23:16];
            4'd6:    res = a[31:24];
            4'd7:    res = b[31:24];
            4'd8:    res = a[7:0];
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/op_fifo.sv
// Generic FIFO: head data readable combinationally, zero-latency pop.
// Push ignored when full, pop ignored when empty; synchronous active-low reset.
module op_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mult_operand_feeder.sv
// Buffers operand pairs and feeds them byte-serially to the shift-add multiplier.
// Start at +2 cycles from accept when idle; 11 bus cycles per operation; in_ready = FIFO not full.
module mult_operand_feeder
    import mult_feed_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic [OPND_W-1:0]       a_in,
    input  logic [OPND_W-1:0]       b_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    rdy,
    output logic                    start,
    output logic [BUS_W-1:0]        M,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    feed_state_t           state;
    feed_state_t           next_state;
    logic [3:0]            idx;
    logic [3:0]            idx_nxt;
    logic [2*OPND_W-1:0]   hold;
    logic [2*OPND_W-1:0]   head;
    logic [BUS_W-1:0]      m_q;
    logic                  ready_en;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    // ready_en keeps in_ready low until the first edge after reset release.
    assign in_ready = rst_b && ready_en && !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && !fifo_empty && rdy;
    assign idx_nxt  = idx + 4'd1;

    assign start = (state == START);
    assign busy  = (state != IDLE);
    assign M     = m_q;

    op_fifo #(
        .WIDTH (2*OPND_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_b    (rst_b),
        .push     (push),
        .push_dat ({a_in, b_in}),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (pop) next_state = START;
            START:    next_state = GAP;
            GAP:      next_state = FEED;
            FEED:     if (idx == LAST_IDX) next_state = WAIT_RDY;
            WAIT_RDY: if (rdy) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // M is registered one cycle ahead so each byte is stable for its whole FEED cycle.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state    <= IDLE;
            idx      <= '0;
            hold     <= '0;
            m_q      <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            state    <= next_state;
            if (pop) begin
                hold <= head;
            end
            case (state)
                GAP: begin
                    idx <= '0;
                    m_q <= feed_byte(hold, 4'd0);
                end
                FEED: begin
                    if (idx == LAST_IDX) begin
                        m_q <= '0;
                    end else begin
                        idx <= idx_nxt;
                        m_q <= feed_byte(hold, idx_nxt);
                    end
                end
                default: m_q <= '0;
            endcase
        end
    end

endmodule
